// File: rtl/ahb2_cmd_master_pkg.sv
// Shared AHB2 constants used by the command master and its slaves.
package ahb2_cmd_master_pkg;

  // Transfer type encodings driven on htrans.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Slave response encodings seen on hresp.
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only single-word, single-beat transfers are issued.
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/ahb2_cmd_master_if.sv
// AHB2 bus bundle with master and slave views, shared by masters, slaves
// and bench-level bus models.
interface ahb2_cmd_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [31:0]           hwdata;
  logic [31:0]           hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb2_cmd_master.sv
// AHB-Lite initiator: converts a valid/ready command stream into pipelined
// single-word AHB transfers and returns one response pulse per command.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_valid may be raised at any time and the command
// fields must be stable while cmd_valid is high. rsp_valid is a one-cycle
// pulse with no backpressure; responses come back in command order.
module ahb2_cmd_master
  import ahb2_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  // Address-phase slot (only the word address is kept).
  logic                  a_valid_q, a_valid_d;
  logic                  a_write_q, a_write_d;
  logic [ADDR_WIDTH-1:2] a_addr_q,  a_addr_d;
  logic [31:0]           a_wdata_q, a_wdata_d;
  // Data-phase slot.
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [31:0]           d_wdata_q, d_wdata_d;
  // Second cycle of a two-cycle ERROR response.
  logic                  err2_q,    err2_d;
  // Response registers.
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic err1;
  logic advance;
  logic accept;
  logic d_done;
  logic unused_addr_lsbs;

  // Byte-lane bits of the command address never reach the bus.
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  // Handshake and pipeline-advance conditions for the current cycle.
  always_comb begin
    err1      = d_valid_q && !hready && (hresp == HRESP_ERROR);
    advance   = hready && !err2_q;
    cmd_ready = (!a_valid_q || advance) && !err1;
    accept    = cmd_valid && cmd_ready;
    d_done    = d_valid_q && hready;
  end

  // Next-state for both phase slots, the error flag and the response.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    err2_d      = err2_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;

    // A new command may land either when the slot is empty (even during a
    // stall, where it waits for hready) or as the current one moves on.
    if (accept) begin
      a_valid_d = 1'b1;
      a_write_d = cmd_write;
      a_addr_d  = cmd_addr[ADDR_WIDTH-1:2];
      a_wdata_d = cmd_wdata;
    end else if (advance) begin
      a_valid_d = 1'b0;
    end

    // During the ERROR second cycle the a slot is cancelled on the bus but
    // kept here, so it simply reissues next cycle.
    if (advance) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end

    err2_d = err2_q ? !hready : err1;

    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = d_write_q;
      rsp_error_d = (hresp == HRESP_ERROR);
      rsp_rdata_d = (!d_write_q && hresp == HRESP_OKAY) ? hrdata : 32'h0;
    end
  end

  // State registers; reset abandons anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      err2_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      err2_q      <= err2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus and response outputs come straight from the registers.
  always_comb begin
    htrans    = (a_valid_q && !err2_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr     = {a_addr_q, 2'b00};
    hwrite    = a_write_q;
    hsize     = HSIZE_WORD;
    hburst    = HBURST_SINGLE;
    hwdata    = d_wdata_q;
    rsp_valid = rsp_valid_q;
    rsp_write = rsp_write_q;
    rsp_error = rsp_error_q;
    rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_ahb2_cmd_master.sv
// Bench for ahb2_cmd_master: memory-slave bus model with scripted or random
// wait states and an error address region, plus a command-level reference
// model predicting every response in order.
module tb_ahb2_cmd_master;
  import ahb2_cmd_master_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_error;
  logic [31:0]   rsp_rdata;

  ahb2_cmd_master_if #(.ADDR_WIDTH(AW)) bus ();

  ahb2_cmd_master #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .haddr     (bus.haddr),
    .htrans    (bus.htrans),
    .hwrite    (bus.hwrite),
    .hsize     (bus.hsize),
    .hburst    (bus.hburst),
    .hwdata    (bus.hwdata),
    .hrdata    (bus.hrdata),
    .hready    (bus.hready),
    .hresp     (bus.hresp)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];   // {write, error, rdata}
  int          acc_q[$];   // acceptance cycle
  int          lat_q[$];   // required latency, -1 = not checked
  int          next_lat;
  logic [31:0] ref_mem [logic [31:0]];

  // ---------------- slave model state ----------------
  logic [31:0] slv_mem [logic [31:0]];
  bit          s_dvalid, s_dwrite, s_err, s_err_seen, s_err1_now, s_rand;
  logic [31:0] s_daddr;
  int          s_wait;
  int          s_plan[$];
  bit          p_hold, p_err, p_nonseq, p_dwrite;
  logic [31:0] p_haddr, p_hwdata;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_err_addr(input logic [31:0] a);
    return a[15:12] == 4'h2;
  endfunction

  // Reference model: the outcome of a command follows from the address map
  // and the memory contents as left by earlier commands in order.
  task automatic model_accept(input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] key;
    bit          e;
    logic [31:0] rd;
    key = a & 32'hFFFF_FFFC;
    e   = is_err_addr(a);
    rd  = 32'h0;
    if (!w && !e && ref_mem.exists(key)) rd = ref_mem[key];
    if (w && !e) ref_mem[key] = d;
    exp_q.push_back({w, e, rd});
    acc_q.push_back(cyc);
    lat_q.push_back(next_lat);
  endtask

  task automatic monitor_step();
    logic [33:0] e;
    int a, l;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        l = lat_q.pop_front();
        check_eq("rsp", {30'd0, rsp_write, rsp_error, rsp_rdata}, {30'd0, e});
        if (l >= 0) check_eq("rsp_latency", 64'(cyc - a), 64'(l));
      end
    end
  endtask

  // One cycle of the memory slave, evaluated after the bus settled.
  task automatic slave_step();
    if (p_hold) begin
      if (p_nonseq) check_eq("hold_haddr", 64'(bus.haddr), 64'(p_haddr));
      if (p_dwrite) check_eq("hold_hwdata", 64'(bus.hwdata), 64'(p_hwdata));
      if (!p_err && p_nonseq) check_eq("hold_htrans", 64'(bus.htrans), 64'(HTRANS_NONSEQ));
    end
    s_err1_now  = 1'b0;
    bus.hrdata  = $urandom();
    if (!s_dvalid) begin
      bus.hready = 1'b1; bus.hresp = HRESP_OKAY;
    end else if (s_wait > 0) begin
      bus.hready = 1'b0; bus.hresp = HRESP_OKAY; s_wait--;
    end else if (s_err && !s_err_seen) begin
      bus.hready = 1'b0; bus.hresp = HRESP_ERROR; s_err_seen = 1'b1; s_err1_now = 1'b1;
    end else if (s_err) begin
      bus.hready = 1'b1; bus.hresp = HRESP_ERROR;
      check_eq("err2_htrans_idle", 64'(bus.htrans), 64'(HTRANS_IDLE));
    end else begin
      bus.hready = 1'b1; bus.hresp = HRESP_OKAY;
      if (s_dwrite) slv_mem[s_daddr] = bus.hwdata;
      else bus.hrdata = slv_mem.exists(s_daddr) ? slv_mem[s_daddr] : 32'h0;
    end
    p_hold   = !bus.hready;
    p_err    = s_err1_now;
    p_nonseq = (bus.htrans == HTRANS_NONSEQ);
    p_haddr  = bus.haddr;
    p_hwdata = bus.hwdata;
    p_dwrite = s_dvalid && s_dwrite;
    if (bus.hready) begin
      if (bus.htrans == HTRANS_NONSEQ) begin
        check_eq("haddr_align", 64'(bus.haddr[1:0]), 64'd0);
        check_eq("hsize", 64'(bus.hsize), 64'(HSIZE_WORD));
        check_eq("hburst", 64'(bus.hburst), 64'(HBURST_SINGLE));
        s_dvalid   = 1'b1;
        s_daddr    = bus.haddr;
        s_dwrite   = bus.hwrite;
        s_err      = is_err_addr(bus.haddr);
        s_err_seen = 1'b0;
        if (s_plan.size() > 0) s_wait = s_plan.pop_front();
        else s_wait = s_rand ? int'($urandom_range(0, 2)) : 0;
      end else begin
        s_dvalid = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output bit acc);
    @(negedge clk);
    monitor_step();
    slave_step();
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    #3;
    if (!bus.hready && bus.htrans == HTRANS_NONSEQ) check_eq("ready_in_wait", 64'(cmd_ready), 64'd0);
    if (s_err1_now) check_eq("ready_in_err1", 64'(cmd_ready), 64'd0);
    acc = v && cmd_ready && rst_n;
    if (acc) model_accept(w, a, d);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom(), $urandom(), acc);
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input bit first_try);
    bit acc;
    int tries;
    tries    = 0;
    next_lat = lat;
    do begin
      tick(1'b1, w, a, d, acc);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    else if (first_try) check_eq("accept_first_cycle", 64'(tries), 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      idle(1);
      k++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_htrans"},    64'(bus.htrans), 64'(HTRANS_IDLE));
    check_eq({tag, "_haddr"},     64'(bus.haddr), 64'd0);
    check_eq({tag, "_hwdata"},    64'(bus.hwdata), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_rest"},  {30'd0, rsp_write, rsp_error, rsp_rdata}, 64'd0);
    check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          w;
    logic [31:0] a;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    bus.hready = 1'b1; bus.hresp = HRESP_OKAY; bus.hrdata = '0;
    s_dvalid = 1'b0; s_rand = 1'b0; p_hold = 1'b0; next_lat = -1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-wait loopback with latency.
    send(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3, 1'b1);
    send(1'b0, 32'h0000_1000, 32'h0, 3, 1'b1);
    drain();

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++) send(1'b1, 32'(i * 4), 32'(i + 1), 3, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 32'h0, 3, 1'b1);
    drain();

    // Two wait states on a write with a read queued behind it.
    s_plan.push_back(2);
    send(1'b1, 32'h0000_0040, 32'hA5A5_0001, 5, 1'b1);
    send(1'b0, 32'h0000_0004, 32'h0, 5, 1'b1);
    drain();

    // ERROR on a write while a read waits in the address phase.
    send(1'b1, 32'h0000_3000, 32'h1234_5678, 3, 1'b1);
    drain();
    send(1'b1, 32'h0000_2000, 32'hBAD0_0000, 4, 1'b1);
    send(1'b0, 32'h0000_3000, 32'h0, 5, 1'b1);
    drain();
    send(1'b0, 32'h0000_2000, 32'h0, 4, 1'b1);
    drain();

    // Asynchronous reset during a stalled data phase.
    s_plan.push_back(8);
    send(1'b0, 32'h0000_0010, 32'h0, -1, 1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete(); acc_q.delete(); lat_q.delete();
    s_dvalid = 1'b0; s_plan.delete(); p_hold = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    send(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 3, 1'b1);
    send(1'b0, 32'h0000_0044, 32'h0, 3, 1'b1);
    drain();

    // Random traffic with random wait states and error-region hits.
    s_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        w = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 5) == 0) a = 32'h0000_2000 + 32'($urandom_range(0, 7) * 4);
        else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        send(w, a, $urandom(), -1, 1'b0);
      end else begin
        idle(1);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2_cmd_master.md
Name: ahb2_cmd_master

Overview:
- AHB-Lite (AHB2) initiator that turns a simple valid/ready command stream into single-word AHB transfers. It drives the shared AHB2 bus toward slaves such as the block-RAM memory slave, and returns one response per command.
- Fully pipelined: one address phase and one data phase can be in flight together, so back-to-back commands issue on consecutive cycles.
- Handles slave wait states and the two-cycle ERROR response, including cancel and replay of the pending address phase.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and haddr; must be ≥3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored (forced 0 on haddr)
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_write  out  1  type of the completed command
- rsp_rdata  out  32  read data; 0 for writes and errored reads
- rsp_error  out  1  slave returned ERROR
- haddr  out  ADDR_WIDTH  AHB address
- htrans  out  2  IDLE or NONSEQ only
- hwrite  out  1  AHB direction
- hsize  out  3  always WORD (3'b010)
- hburst  out  3  always SINGLE
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  bus ready (muxed slave hreadyo)
- hresp  in  1  OKAY/ERROR

Behaviour:
- State registers:
  - Address-phase slot: a_valid, a_write, a_addr, a_wdata.
  - Data-phase slot: d_valid, d_write, d_wdata.
  - err2 flag.
  - Response registers.
- Reset values: a_valid = d_valid = err2 = rsp_valid = 0. haddr, hwdata and rsp_rdata = 0. rsp_write = rsp_error = 0. htrans = IDLE.
- Asynchronous reset mid-transfer abandons all in-flight commands; no responses are issued for them.
- Bus outputs:
  - htrans = NONSEQ when a_valid && !err2, else IDLE.
  - haddr = {a_addr[ADDR_WIDTH-1:2], 2'b00}; hwrite = a_write.
  - hwdata = d_wdata, held stable across wait states.
- Address phase advance, when hready=1 && !err2:
  - d_valid <= a_valid and d_write/d_wdata <= a fields.
  - a slot loads the accepted command, else clears.
- cmd_ready:
  - = (!a_valid || (hready && !err2)) && !err1, where err1 = d_valid && !hready && hresp==ERROR.
  - While a_valid=0 and hready=0, a command may be accepted; it is then held in the address phase until hready.
- Data phase completion: a cycle with d_valid && hready.
  - Next cycle: rsp_valid=1, rsp_write=d_write, rsp_error=(hresp==ERROR).
  - rsp_rdata = hrdata for an OKAY read, else 0.
- Latency (zero-wait slave): command accepted at edge ending cycle T → address phase T+1 → data phase T+2 → rsp_valid in T+3. Each wait cycle adds 1.
- ERROR handling:
  - err1 cycle: set err2 at the edge; a slot frozen; cmd_ready=0.
  - err2 cycle (hready=1 required by protocol): htrans forced IDLE, so any pending a-slot transfer is cancelled on the bus. The data phase completes with rsp_error=1; d_valid clears; err2 clears.
  - The a-slot contents are retained and reissued as NONSEQ in the following cycle. Cancelled commands are never dropped or duplicated.
  - An ERROR response arriving on a replayed transfer is handled identically.
- Ordering: responses return in strict command order, exactly one per accepted command.
- hresp ERROR with hready=1 outside err2 (protocol violation): treated as an errored completion.

Decomposition:
- Shared AHB2 package holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/HRESP_ERROR (already used by slaves)
  - HSIZE_WORD
  - HBURST_SINGLE
- No sub-module. The two phase slots are small enough to live inline.
- A later variant exposes the bus through an AHB2 master modport; this version uses discrete ports.

Test Plan:
- Memory-slave loopback, zero wait: write 0x0000_1000 ← 0xDEAD_BEEF, then read 0x1000 → rsp_valid at T+3 with rsp_rdata=0xDEAD_BEEF, rsp_error=0.
- Back-to-back: 4 writes (0x0,0x4,0x8,0xC ← 1..4) on consecutive cycles → cmd_ready stays 1, htrans NONSEQ for 4 cycles, hwdata 1..4 each one cycle later, 4 rsp pulses in order.
- Wait states: slave holds hready=0 for 2 cycles on a data phase with the next read queued → haddr/hwdata/htrans stable for 2 cycles, cmd_ready=0, response delayed by exactly 2 cycles.
- Error + replay: write 0x2000 gets ERROR while read 0x3000 sits in the address phase → err2 cycle htrans=IDLE, rsp_error=1 for the write, read 0x3000 reissued next cycle, completes OKAY with correct data.
- Reset mid-operation: assert rst_n=0 asynchronously during a stalled data phase → outputs at reset values immediately, no rsp_valid after release, next command behaves as first transfer.
